spi_bus_arbiter: RTL and testbench

- Shares one SPI_Master instance between N_REQ requesters (e.g. ROM controller, motor controller, sensor poller).
- Grants the bus round-robin for one whole multi-byte transaction and drives the master's start/ack/tx/enable inputs.
- Asserts the granted requester's slave select and returns each received byte to that requester.
- Sits between requester controllers and SPI_Master; replaces per-controller ena_2clk and spi_ss_n generation.

---
 rtl/spi_bus_arbiter_if.sv | 34 +++
 rtl/spi_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Bundled requester and SPI_Master-side signals of spi_bus_arbiter.
// The "master" modport is the arbiter's view; "slave" is the environment's view.
interface spi_bus_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ-1:0]   gnt_o;
    logic [N_REQ-1:0]   tx_valid_i;
    logic [N_REQ-1:0]   tx_last_i;
    logic [8*N_REQ-1:0] tx_data_i;
    logic [N_REQ-1:0]   tx_ready_o;
    logic [N_REQ-1:0]   rx_valid_o;
    logic [7:0]         rx_data_o;
    logic [N_REQ-1:0]   ss_n_o;
    logic               ena_2clk_o;
    logic               spi_start_o;
    logic               spi_ack_o;
    logic [7:0]         spi_tx_o;
    logic               spi_busy_i;
    logic [7:0]         spi_rx_i;
    logic               timeout_o;

    modport master (
        input  req_i, tx_valid_i, tx_last_i, tx_data_i, spi_busy_i, spi_rx_i,
        output gnt_o, tx_ready_o, rx_valid_o, rx_data_o, ss_n_o, ena_2clk_o,
        output spi_start_o, spi_ack_o, spi_tx_o, timeout_o
    );

    modport slave (
        output req_i, tx_valid_i, tx_last_i, tx_data_i, spi_busy_i, spi_rx_i,
        input  gnt_o, tx_ready_o, rx_valid_o, rx_data_o, ss_n_o, ena_2clk_o,
        input  spi_start_o, spi_ack_o, spi_tx_o, timeout_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI_Master between N_REQ requesters for whole transactions.
// Optional per-byte busy watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SS_SETUP = 2,
    parameter int unsigned SS_HOLD  = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned ROT_W   = $clog2(2 * N_REQ);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (N_REQ < 2 || N_REQ > 8 || CLK_DIV < 2 || SS_SETUP < 1 || SS_HOLD < 1 ||
        TIMEOUT < 1) begin : g_param_check
        $error("spi_bus_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWaitData,
        StWaitBusy,
        StXfer,
        StHold
    } state_e;

    state_e             r_state, w_state_next;
    logic [DIV_W-1:0]   r_div;
    logic [N_REQ-1:0]   r_gnt, w_gnt_next;
    logic [IDX_W-1:0]   r_gidx, w_gidx_next;
    logic [IDX_W-1:0]   r_ptr, w_ptr_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [7:0]         r_tx, w_tx_next;
    logic               r_last, w_last_next;
    logic               r_start, w_start_next;
    logic               r_ack, w_ack_next;
    logic [N_REQ-1:0]   r_rx_valid, w_rx_valid_next;
    logic [7:0]         r_rx_data, w_rx_data_next;
    logic [N_REQ-1:0]   w_tx_ready;

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [ROT_W-1:0]   w_base;
    logic [ROT_W-1:0]   w_win_sum;
    logic [IDX_W-1:0]   w_win_off;
    logic [IDX_W-1:0]   w_win_idx;
    logic [N_REQ-1:0]   w_win_oh;
    logic               w_win_found;

    logic               w_g_valid;
    logic               w_g_last;
    logic               w_g_req;
    logic [7:0]         w_g_data;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   r_tmo, w_tmo_next;
    logic               r_timeout, w_timeout_next;
    logic               w_tmo_hit;
`endif

    // Free-running SCK enable divider, independent of the transaction FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Rotate requests so bit 0 is the requester just after the pointer.
    assign w_req_dbl = {bus.req_i, bus.req_i};
    assign w_base    = ROT_W'(r_ptr) + ROT_W'(1);
    assign w_req_rot = w_req_dbl[w_base +: N_REQ];

    always_comb begin
        w_win_found = 1'b0;
        w_win_off   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_win_found = 1'b1;
                w_win_off   = IDX_W'(i);
            end
        end
    end

    assign w_win_sum = w_base + ROT_W'(w_win_off);
    assign w_win_idx = (w_win_sum >= ROT_W'(N_REQ)) ? IDX_W'(w_win_sum - ROT_W'(N_REQ))
                                                    : IDX_W'(w_win_sum);
    assign w_win_oh  = N_REQ'(1) << w_win_idx;

    assign w_g_valid = bus.tx_valid_i[r_gidx];
    assign w_g_last  = bus.tx_last_i[r_gidx];
    assign w_g_req   = bus.req_i[r_gidx];
    assign w_g_data  = bus.tx_data_i[{r_gidx, 3'b000} +: 8];

`ifdef SPI_ARB_TIMEOUT_EN
    assign w_tmo_hit = ((r_state == StWaitBusy) || (r_state == StXfer)) &&
                       (r_tmo == TMO_W'(TIMEOUT - 1));
`endif

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_gidx_next     = r_gidx;
        w_ptr_next      = r_ptr;
        w_cnt_next      = r_cnt;
        w_tx_next       = r_tx;
        w_last_next     = r_last;
        w_rx_data_next  = r_rx_data;
        w_start_next    = 1'b0;
        w_ack_next      = 1'b0;
        w_rx_valid_next = '0;
        w_tx_ready      = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        w_tmo_next      = r_tmo;
        w_timeout_next  = r_timeout;
`endif

        unique case (r_state)
            StIdle: begin
                if (w_win_found) begin
                    w_gnt_next   = w_win_oh;
                    w_gidx_next  = w_win_idx;
                    w_cnt_next   = '0;
                    w_state_next = StSetup;
                end
            end
            StSetup: begin
                if (r_cnt == CNT_W'(SS_SETUP - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = StWaitData;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StWaitData: begin
                if (w_g_valid) begin
                    w_tx_ready   = r_gnt;
                    w_tx_next    = w_g_data;
                    w_last_next  = w_g_last;
                    w_start_next = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    w_tmo_next   = '0;
`endif
                    w_state_next = StWaitBusy;
                end else if (!w_g_req) begin
                    w_cnt_next   = '0;
                    w_state_next = StHold;
                end
            end
            StWaitBusy: begin
                if (bus.spi_busy_i) begin
                    w_state_next = StXfer;
                end
            end
            StXfer: begin
                if (!bus.spi_busy_i) begin
                    w_rx_data_next  = bus.spi_rx_i;
                    w_rx_valid_next = r_gnt;
                    w_ack_next      = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = r_last ? StHold : StWaitData;
                end
            end
            StHold: begin
                if (r_cnt == CNT_W'(SS_HOLD - 1)) begin
                    w_gnt_next   = '0;
                    w_ptr_next   = r_gidx;
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_gnt_next   = '0;
                w_state_next = StIdle;
            end
        endcase

`ifdef SPI_ARB_TIMEOUT_EN
        if ((r_state == StWaitBusy) || (r_state == StXfer)) begin
            w_tmo_next = r_tmo + TMO_W'(1);
        end
        // A byte finishing on the very last allowed cycle still counts as good.
        if (w_tmo_hit && !((r_state == StXfer) && !bus.spi_busy_i)) begin
            w_timeout_next  = 1'b1;
            w_ack_next      = 1'b1;
            w_rx_valid_next = r_gnt;
            w_rx_data_next  = 8'hFF;
            w_cnt_next      = '0;
            w_state_next    = StHold;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_tx       <= '0;
            r_last     <= 1'b0;
            r_start    <= 1'b0;
            r_ack      <= 1'b0;
            r_rx_valid <= '0;
            r_rx_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_gidx     <= w_gidx_next;
            r_ptr      <= w_ptr_next;
            r_cnt      <= w_cnt_next;
            r_tx       <= w_tx_next;
            r_last     <= w_last_next;
            r_start    <= w_start_next;
            r_ack      <= w_ack_next;
            r_rx_valid <= w_rx_valid_next;
            r_rx_data  <= w_rx_data_next;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo     <= w_tmo_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.gnt_o       = r_gnt;
    assign bus.ss_n_o      = ~r_gnt;
    assign bus.tx_ready_o  = w_tx_ready;
    assign bus.rx_valid_o  = r_rx_valid;
    assign bus.rx_data_o   = r_rx_data;
    assign bus.ena_2clk_o  = (r_div == DIV_W'(CLK_DIV - 1));
    assign bus.spi_start_o = r_start;
    assign bus.spi_ack_o   = r_ack;
    assign bus.spi_tx_o    = r_tx;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a small SPI_Master model that echoes ~tx.
// Define SPI_ARB_TIMEOUT_EN on both RTL and bench to exercise the busy watchdog.
module tb_spi_bus_arbiter;
    localparam int unsigned N_REQ    = 2;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned SS_SETUP = 2;
    localparam int unsigned SS_HOLD  = 2;
    localparam int unsigned TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();

    spi_bus_arbiter #(
        .N_REQ   (N_REQ),
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .SS_HOLD (SS_HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // SPI_Master model: busy one cycle after start, ~tx returned three cycles later.
    logic       stuck = 1'b0;
    logic [7:0] m_tx;
    logic [1:0] m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.spi_busy_i <= 1'b0;
            bus.spi_rx_i   <= 8'h00;
            m_tx           <= 8'h00;
            m_cnt          <= 2'd0;
        end else if (bus.spi_start_o) begin
            bus.spi_busy_i <= 1'b1;
            m_tx           <= bus.spi_tx_o;
            m_cnt          <= 2'd3;
        end else if (bus.spi_busy_i && !stuck) begin
            if (m_cnt == 2'd1) begin
                bus.spi_busy_i <= 1'b0;
                bus.spi_rx_i   <= ~m_tx;
            end else begin
                m_cnt <= m_cnt - 2'd1;
            end
        end
    end

    logic [7:0] start_tx [$];
    logic [7:0] rx_q [$];
    logic [1:0] rxv_q [$];
    logic [1:0] grant_q [$];
    int         both_low = 0;
    int         no_gap = 0;
    logic [1:0] gnt_prev = 2'b00;
    always @(negedge clk) begin
        if (bus.spi_start_o) start_tx.push_back(bus.spi_tx_o);
        if (bus.rx_valid_o != 2'b00) begin
            rx_q.push_back(bus.rx_data_o);
            rxv_q.push_back(bus.rx_valid_o);
        end
        if (bus.ss_n_o == 2'b00) both_low <= both_low + 1;
        if (bus.gnt_o != 2'b00 && gnt_prev != 2'b00 && bus.gnt_o != gnt_prev)
            no_gap <= no_gap + 1;
        if (bus.gnt_o != 2'b00 && gnt_prev == 2'b00) grant_q.push_back(bus.gnt_o);
        gnt_prev <= bus.gnt_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input int k, input logic [7:0] d, input logic last);
        int t;
        bus.tx_data_i[8*k +: 8] = d;
        bus.tx_last_i[k]        = last;
        bus.tx_valid_i[k]       = 1'b1;
        #1;
        t = 0;
        while (!bus.tx_ready_o[k] && t < 200) begin
            tick();
            t++;
        end
        chk($sformatf("tx_ready_%0d_%0h", k, d), {31'd0, bus.tx_ready_o[k]}, 32'd1);
        tick();
        bus.tx_valid_i[k] = 1'b0;
        bus.tx_last_i[k]  = 1'b0;
    endtask

    initial begin
        int pulses, last_c, gap_bad, idle_bad, t, n, s0, r0, g0, bl0, ng0;
        bus.req_i      = '0;
        bus.tx_valid_i = '0;
        bus.tx_last_i  = '0;
        bus.tx_data_i  = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_ss_n", bus.ss_n_o, 2'b11);
        chk("rst_tx_ready", bus.tx_ready_o, 0);
        chk("rst_rx_valid", bus.rx_valid_o, 0);
        chk("rst_rx_data", bus.rx_data_o, 0);
        chk("rst_start", bus.spi_start_o, 0);
        chk("rst_ack", bus.spi_ack_o, 0);
        chk("rst_spi_tx", bus.spi_tx_o, 0);
        chk("rst_ena", bus.ena_2clk_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        rst_n = 1'b1;

        // Idle bus: ena every 4th cycle, nothing granted
        pulses = 0; last_c = -1; gap_bad = 0; idle_bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.ena_2clk_o) begin
                if (last_c >= 0 && c - last_c != 4) gap_bad++;
                pulses++;
                last_c = c;
            end
            if (bus.ss_n_o != 2'b11 || bus.gnt_o != 2'b00) idle_bad++;
        end
        chk("ena_pulses", pulses, 3);
        chk("ena_spacing", gap_bad, 0);
        chk("idle_bus", idle_bad, 0);

        // Three-byte transaction on requester 0
        s0 = start_tx.size(); r0 = rx_q.size();
        bus.req_i[0] = 1'b1;
        send_byte(0, 8'hA5, 1'b0);
        chk("ss0_low_mid", bus.ss_n_o, 2'b10);
        send_byte(0, 8'h5A, 1'b0);
        send_byte(0, 8'h3C, 1'b1);
        bus.req_i[0] = 1'b0;
        t = 0;
        while (!bus.spi_ack_o && t < 100) begin tick(); t++; end
        chk("last_ack_wait", {31'd0, bus.spi_ack_o}, 1);
        chk("ss0_low_at_ack", bus.ss_n_o, 2'b10);
        n = 0;
        while (bus.ss_n_o[0] == 1'b0 && n < 100) begin tick(); n++; end
        chk("ss0_hold_cycles", n, SS_HOLD);
        chk("gnt_after_hold", bus.gnt_o, 0);
        chk("starts_3", start_tx.size() - s0, 3);
        chk("tx_b0", start_tx[s0], 8'hA5);
        chk("tx_b1", start_tx[s0+1], 8'h5A);
        chk("tx_b2", start_tx[s0+2], 8'h3C);
        chk("rx_cnt_3", rx_q.size() - r0, 3);
        chk("rx_b0", rx_q[r0], 8'h5A);
        chk("rx_b1", rx_q[r0+1], 8'hA5);
        chk("rx_b2", rx_q[r0+2], 8'hC3);
        chk("rxv_b0", rxv_q[r0], 2'b01);
        chk("rxv_b2", rxv_q[r0+2], 2'b01);

        // Requester 1 ends after one byte without last
        repeat (3) tick();
        s0 = start_tx.size();
        bus.req_i = 2'b10;
        send_byte(1, 8'h96, 1'b0);
        t = 0;
        while (!bus.rx_valid_o[1] && t < 100) begin tick(); t++; end
        chk("drop_rx_valid", bus.rx_valid_o, 2'b10);
        chk("drop_rx_data", bus.rx_data_o, 8'h69);
        bus.req_i = 2'b00;
        n = 0;
        while (bus.ss_n_o[1] == 1'b0 && n < 100) begin tick(); n++; end
        chk("drop_hold_cycles", n, SS_HOLD + 1);
        repeat (20) tick();
        chk("drop_no_more_start", start_tx.size() - s0, 1);
        chk("drop_gnt", bus.gnt_o, 0);

        // Both requesting one-byte transactions continuously
        g0 = grant_q.size(); bl0 = both_low; ng0 = no_gap; s0 = start_tx.size();
        bus.tx_data_i  = 16'h2211;
        bus.tx_last_i  = 2'b11;
        bus.tx_valid_i = 2'b11;
        bus.req_i      = 2'b11;
        t = 0;
        while (grant_q.size() < g0 + 5 && t < 500) begin tick(); t++; end
        bus.req_i      = 2'b00;
        bus.tx_valid_i = 2'b00;
        bus.tx_last_i  = 2'b00;
        chk("alt_grant_wait", grant_q.size() - g0, 5);
        t = 0;
        while (bus.gnt_o != 2'b00 && t < 100) begin tick(); t++; end
        chk("alt_g0", grant_q[g0], 2'b01);
        chk("alt_g1", grant_q[g0+1], 2'b10);
        chk("alt_g2", grant_q[g0+2], 2'b01);
        chk("alt_g3", grant_q[g0+3], 2'b10);
        chk("alt_g4", grant_q[g0+4], 2'b01);
        chk("alt_bytes", start_tx.size() - s0, 4);
        chk("alt_both_low", both_low - bl0, 0);
        chk("alt_no_idle_gap", no_gap - ng0, 0);

        // Reset while the master is busy
        repeat (3) tick();
        stuck = 1'b1;
        bus.req_i = 2'b10;
        send_byte(1, 8'h11, 1'b1);
        t = 0;
        while (!bus.spi_busy_i && t < 100) begin tick(); t++; end
        tick(); tick();
        chk("pre_rst_gnt", bus.gnt_o, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss_n", bus.ss_n_o, 2'b11);
        chk("mid_rst_gnt", bus.gnt_o, 0);
        chk("mid_rst_start", bus.spi_start_o, 0);
        bus.req_i = 2'b00;
        stuck = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus.req_i = 2'b11;
        t = 0;
        while (bus.gnt_o == 2'b00 && t < 100) begin tick(); t++; end
        chk("post_rst_first_gnt", bus.gnt_o, 2'b01);
        bus.req_i = 2'b00;
        t = 0;
        while (bus.gnt_o != 2'b00 && t < 100) begin tick(); t++; end
        chk("post_rst_release", bus.gnt_o, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Busy stuck high: watchdog fires 16 cycles after start
        repeat (3) tick();
        stuck = 1'b1;
        bus.req_i = 2'b01;
        send_byte(0, 8'h42, 1'b1);
        chk("tmo_start", bus.spi_start_o, 1);
        n = 0;
        while (!bus.timeout_o && n < 100) begin tick(); n++; end
        chk("tmo_cycles", n, TIMEOUT);
        chk("tmo_rx_valid", bus.rx_valid_o, 2'b01);
        chk("tmo_rx_data", bus.rx_data_o, 8'hFF);
        chk("tmo_ack", bus.spi_ack_o, 1);
        bus.req_i = 2'b00;
        t = 0;
        while (bus.gnt_o != 2'b00 && t < 100) begin tick(); t++; end
        chk("tmo_released", bus.ss_n_o, 2'b11);
        repeat (5) tick();
        chk("tmo_sticky", bus.timeout_o, 1);
        rst_n = 1'b0;
        tick();
        chk("tmo_cleared", bus.timeout_o, 0);
        stuck = 1'b0;
        rst_n = 1'b1;
        tick();
`else
        chk("timeout_tied_low", bus.timeout_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
